// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its instruction-side controller.
// Holds the 4-bit ALU opcode encoding, the instruction op codes that do not map
// one-to-one onto ALU opcodes, the instruction field positions, the controller
// state encoding and a small decode helper.
package alu_pkg;

  // ALU opcode encoding
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b0111;
  localparam logic [3:0] OP_PASSA = 4'b1000;
  localparam logic [3:0] OP_PASSB = 4'b1001;
  localparam logic [3:0] OP_ZERO  = 4'b1010;

  // Instruction op codes outside the direct ALU range
  localparam logic [3:0] I_CMP = 4'b1011;
  localparam logic [3:0] I_LDI = 4'b1111;

  // Instruction field bit positions
  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 12;
  localparam int F_RD_HI  = 11;
  localparam int F_RD_LO  = 10;
  localparam int F_RS1_HI = 9;
  localparam int F_RS1_LO = 8;
  localparam int F_RS2_HI = 7;
  localparam int F_RS2_LO = 6;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  // Register file geometry
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_CMP = 2'd1,
    K_LDI = 2'd2,
    K_ILL = 2'd3
  } kind_t;

  // Classify an instruction op code into its execution kind
  function automatic kind_t decode_kind(input logic [3:0] op);
    kind_t k;
    case (op)
      I_CMP:         k = K_CMP;
      I_LDI:         k = K_LDI;
      4'b1100,
      4'b1101,
      4'b1110:       k = K_ILL;
      default:       k = K_ALU;   // 0000..1010 map straight onto the ALU
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: 4 x WIDTH register file for the ALU controller.
// Ports: clk/rst (async active-high, clears all registers), one write port
// (we/waddr/wdata), two combinational operand read ports (raddr_a/rdata_a,
// raddr_b/rdata_b) and one combinational debug read port (dbg_addr/dbg_data).
module alu_ctrl_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [WIDTH-1:0] regs_r [NUM_REGS];

  // Register storage with single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_r[raddr_a];
  assign rdata_b  = regs_r[raddr_b];
  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: instruction-side initiator for the ALU opcode interface.
// Accepts 16-bit instructions (instr_valid/instr_ready), decodes them to the
// ALU opcode encoding, issues operands from the register file for one cycle
// (alu_req/alu_opcode/alu_a/alu_b), waits ALU_LAT cycles, captures
// alu_result/alu_cout and writes back the result plus Z/C flags (flag_z/flag_c).
// illegal pulses for one cycle on an undefined op; busy is high outside IDLE;
// dbg_addr/dbg_data give a combinational view of the register file.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              alu_req,
  output logic [3:0]        alu_opcode,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

  state_t           state_r, state_nx_s;
  logic [15:0]      instr_r;
  kind_t            kind_s;
  logic [2:0]       cnt_r;
  logic [WIDTH-1:0] res_r;
  logic             cout_r;
  logic             alu_req_r, illegal_r, flag_z_r, flag_c_r;
  logic [3:0]       alu_opcode_r;
  logic [WIDTH-1:0] alu_a_r, alu_b_r;
  logic [WIDTH-1:0] rdata_a_s, rdata_b_s, imm_ext_s, wdata_s;
  logic             accept_s, load_issue_s, rf_we_s, flag_we_s, ill_set_s;

  assign kind_s    = decode_kind(instr_r[F_OP_HI:F_OP_LO]);
  // The size cast zero-extends for WIDTH>8 and truncates for WIDTH<8
  assign imm_ext_s = WIDTH'(instr_r[F_IMM_HI:F_IMM_LO]);

  alu_ctrl_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we_s),
    .waddr    (instr_r[F_RD_HI:F_RD_LO]),
    .wdata    (wdata_s),
    .raddr_a  (instr_r[F_RS1_HI:F_RS1_LO]),
    .rdata_a  (rdata_a_s),
    .raddr_b  (instr_r[F_RS2_HI:F_RS2_LO]),
    .rdata_b  (rdata_b_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:   state_nx_s = instr_valid ? ST_DECODE : ST_IDLE;
      ST_DECODE: begin
        case (kind_s)
          K_ALU, K_CMP: state_nx_s = ST_ISSUE;
          K_LDI:        state_nx_s = ST_WB;
          default:      state_nx_s = ST_IDLE;
        endcase
      end
      ST_ISSUE:  state_nx_s = ST_WAIT;
      ST_WAIT:   state_nx_s = (cnt_r == 3'd0) ? ST_WB : ST_WAIT;
      ST_WB:     state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output decode: per-state strobes for the datapath registers
  always_comb begin
    accept_s     = 1'b0;
    load_issue_s = 1'b0;
    rf_we_s      = 1'b0;
    flag_we_s    = 1'b0;
    ill_set_s    = 1'b0;
    wdata_s      = res_r;
    case (state_r)
      ST_IDLE:   accept_s = instr_valid;
      ST_DECODE: begin
        // Operands are captured on the edge into ISSUE; every earlier
        // writeback has already landed, so dependent instructions see it.
        load_issue_s = (kind_s == K_ALU) || (kind_s == K_CMP);
        ill_set_s    = (kind_s == K_ILL);
      end
      ST_WB: begin
        rf_we_s   = (kind_s == K_ALU) || (kind_s == K_LDI);
        flag_we_s = (kind_s == K_ALU) || (kind_s == K_CMP);
        wdata_s   = (kind_s == K_LDI) ? imm_ext_s : res_r;
      end
      default: accept_s = 1'b0;
    endcase
  end

  // Datapath registers: instruction latch, issue outputs, latency counter,
  // captured ALU response, flags and illegal pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r      <= 16'h0000;
      alu_req_r    <= 1'b0;
      alu_opcode_r <= 4'b0000;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      cnt_r        <= 3'd0;
      res_r        <= {WIDTH{1'b0}};
      cout_r       <= 1'b0;
      flag_z_r     <= 1'b0;
      flag_c_r     <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        instr_r <= instr;
      end
      alu_req_r <= load_issue_s;
      if (load_issue_s) begin
        alu_opcode_r <= (kind_s == K_CMP) ? OP_SUB : instr_r[F_OP_HI:F_OP_LO];
        alu_a_r      <= rdata_a_s;
        alu_b_r      <= rdata_b_s;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= LAT_INIT;
      end else if ((state_r == ST_WAIT) && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if ((state_r == ST_WAIT) && (cnt_r == 3'd0)) begin
        res_r  <= alu_result;
        cout_r <= alu_cout;
      end
      if (flag_we_s) begin
        flag_z_r <= (res_r == {WIDTH{1'b0}});
        flag_c_r <= cout_r;
      end
      illegal_r <= ill_set_s;
    end
  end

  assign instr_ready = (state_r == ST_IDLE) && !rst;
  assign busy        = (state_r != ST_IDLE);
  assign alu_req     = alu_req_r;
  assign alu_opcode  = alu_opcode_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign flag_z      = flag_z_r;
  assign flag_c      = flag_c_r;
  assign illegal     = illegal_r;

endmodule
